// File: rtl/cmn_val_rdy_queue.sv
// Val/rdy FIFO of p_depth entries of p_nbits each, with count-based full/empty tracking.
// Define CMN_VAL_RDY_QUEUE_BYPASS_EN for a zero-latency pass-through when the queue is empty.
module cmn_val_rdy_queue #(
    parameter int p_nbits = 32,
    parameter int p_depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_val,
    output logic                         enq_rdy,
    input  logic [p_nbits-1:0]           enq_msg,
    output logic                         deq_val,
    input  logic                         deq_rdy,
    output logic [p_nbits-1:0]           deq_msg,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int            PW   = $clog2(p_depth);
    localparam int            CW   = $clog2(p_depth + 1);
    localparam logic [CW-1:0] FULL = CW'(p_depth);

    logic [p_nbits-1:0] mem_q [p_depth];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               stored_val;
    logic               enq_fire;
    logic               deq_fire;

    assign stored_val = (count_q != '0);
    assign enq_rdy    = (count_q != FULL);
    assign count      = count_q;

`ifdef CMN_VAL_RDY_QUEUE_BYPASS_EN
    logic bypass;
    logic bypass_fire;

    // An empty queue forwards the producer's message; if the consumer takes it, nothing is stored.
    assign bypass      = !stored_val && enq_val;
    assign bypass_fire = bypass && deq_rdy;
    assign deq_val     = stored_val || bypass;
    assign deq_msg     = bypass ? enq_msg : mem_q[head_q];
    assign enq_fire    = enq_val && enq_rdy && !bypass_fire;
`else
    assign deq_val     = stored_val;
    assign deq_msg     = mem_q[head_q];
    assign enq_fire    = enq_val && enq_rdy;
`endif

    // Only stored entries can be dequeued; a bypassed message never touches the pointers.
    assign deq_fire = stored_val && deq_rdy;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq_fire) head_d = head_q + PW'(1);
        if (enq_fire) tail_d = tail_q + PW'(1);
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; count gates deq_val, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[tail_q] <= enq_msg;
    end

endmodule

// File: tb/tb_cmn_val_rdy_queue.sv
// Self-checking bench for cmn_val_rdy_queue (p_nbits=32, p_depth=4) using a FIFO scoreboard.
// Bypass scenario runs only when CMN_VAL_RDY_QUEUE_BYPASS_EN is defined.
module tb_cmn_val_rdy_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enq_val = 1'b0;
    logic        enq_rdy;
    logic [31:0] enq_msg = '0;
    logic        deq_val;
    logic        deq_rdy = 1'b0;
    logic [31:0] deq_msg;
    logic [2:0]  count;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_msg;

    cmn_val_rdy_queue #(.p_nbits(32), .p_depth(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (deq_val !== 1'b0) begin bad++; $display("FAIL reset_deq_val: got %b expected 0", deq_val); end
        total++; if (enq_rdy !== 1'b1) begin bad++; $display("FAIL reset_enq_rdy: got %b expected 1", enq_rdy); end
        enq_val = 1'b1; enq_msg = 32'hDEADBEEF; sb.push_back(32'hDEADBEEF);
        tick();
        enq_val = 1'b0;
        #1;
        total++; if (deq_val !== 1'b1) begin bad++; $display("FAIL first_deq_val: got %b expected 1", deq_val); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL first_count: got %0d expected 1", count); end
        deq_rdy = 1'b1;
        exp_msg = sb.pop_front();
        total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL first_msg: got %h expected %h", deq_msg, exp_msg); end
        tick();
        deq_rdy = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL first_drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) begin
            enq_val = 1'b1; enq_msg = 32'(i);
            #1;
            total++; if (enq_rdy !== 1'b1) begin bad++; $display("FAIL fill_enq_rdy[%0d]: got %b expected 1", i, enq_rdy); end
            sb.push_back(32'(i));
            tick();
        end
        enq_val = 1'b0;
        #1;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d expected 4", count); end
        total++; if (enq_rdy !== 1'b0) begin bad++; $display("FAIL full_enq_rdy: got %b expected 0", enq_rdy); end
        tick();
        enq_val = 1'b1; enq_msg = 32'h5;
        tick();
        enq_val = 1'b0;
        #1;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL reject_count: got %0d expected 4", count); end
        deq_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (deq_val !== 1'b1) begin bad++; $display("FAIL drain_val[%0d]: got %b expected 1", i, deq_val); end
            exp_msg = sb.pop_front();
            total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL drain_msg[%0d]: got %h expected %h", i, deq_msg, exp_msg); end
            tick();
        end
        #1;
        total++; if (deq_val !== 1'b0) begin bad++; $display("FAIL empty_deq_val: got %b expected 0", deq_val); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_count: got %0d expected 0", count); end
        // deq_rdy held high on an empty queue must not move the head
        tick();
        deq_rdy = 1'b0;
        enq_val = 1'b1; enq_msg = 32'h42; sb.push_back(32'h42);
        tick();
        enq_val = 1'b0;
        #1;
        exp_msg = sb.pop_front();
        total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL empty_head_hold: got %h expected %h", deq_msg, exp_msg); end
        deq_rdy = 1'b1;
        tick();
        deq_rdy = 1'b0;
    endtask

    task automatic test_full_simul();
        for (int i = 1; i <= 4; i++) begin
            enq_val = 1'b1; enq_msg = 32'(i); sb.push_back(32'(i));
            tick();
        end
        enq_val = 1'b1; enq_msg = 32'h9; deq_rdy = 1'b1;
        #1;
        exp_msg = sb.pop_front();
        total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL simul_msg: got %h expected %h", deq_msg, exp_msg); end
        tick();
        enq_val = 1'b0; deq_rdy = 1'b0;
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL simul_count: got %0d expected 3", count); end
        total++; if (enq_rdy !== 1'b1) begin bad++; $display("FAIL simul_enq_rdy: got %b expected 1", enq_rdy); end
        deq_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_msg = sb.pop_front();
            total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, deq_msg, exp_msg); end
            tick();
        end
        deq_rdy = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL simul_end_count: got %0d expected 0", count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            enq_val = 1'b1; enq_msg = 32'hA0 + 32'(i); sb.push_back(32'hA0 + 32'(i));
            tick();
        end
        deq_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_msg = 32'h10 + 32'(i);
            #1;
            total++; if (count !== 3'd2) begin bad++; $display("FAIL steady_count[%0d]: got %0d expected 2", i, count); end
            exp_msg = sb.pop_front();
            total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL steady_msg[%0d]: got %h expected %h", i, deq_msg, exp_msg); end
            sb.push_back(32'h10 + 32'(i));
            tick();
        end
        enq_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            exp_msg = sb.pop_front();
            total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL steady_tail[%0d]: got %h expected %h", i, deq_msg, exp_msg); end
            tick();
        end
        deq_rdy = 1'b0;
        #1;
        total++; if (deq_val !== 1'b0) begin bad++; $display("FAIL steady_end_val: got %b expected 0", deq_val); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            enq_val = 1'b1; enq_msg = 32'hB0 + 32'(i); sb.push_back(32'hB0 + 32'(i));
            tick();
        end
        enq_val = 1'b0;
        #2 reset = 1'b1;
        sb.delete();
        #1;
        total++; if (deq_val !== 1'b0) begin bad++; $display("FAIL async_deq_val: got %b expected 0", deq_val); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL async_count: got %0d expected 0", count); end
        total++; if (enq_rdy !== 1'b1) begin bad++; $display("FAIL async_enq_rdy: got %b expected 1", enq_rdy); end
        #1 reset = 1'b0;
        tick();
        enq_val = 1'b1; enq_msg = 32'hA5; sb.push_back(32'hA5);
        tick();
        enq_val = 1'b0;
        #1;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL post_reset_count: got %0d expected 1", count); end
        exp_msg = sb.pop_front();
        total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL post_reset_msg: got %h expected %h", deq_msg, exp_msg); end
        deq_rdy = 1'b1;
        tick();
        deq_rdy = 1'b0;
    endtask

`ifdef CMN_VAL_RDY_QUEUE_BYPASS_EN
    task automatic test_bypass();
        enq_val = 1'b1; enq_msg = 32'h77; deq_rdy = 1'b1;
        #1;
        total++; if (deq_val !== 1'b1) begin bad++; $display("FAIL bypass_val: got %b expected 1", deq_val); end
        total++; if (deq_msg !== 32'h77) begin bad++; $display("FAIL bypass_msg: got %h expected 00000077", deq_msg); end
        tick();
        enq_val = 1'b0; deq_rdy = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL bypass_count: got %0d expected 0", count); end
        total++; if (deq_val !== 1'b0) begin bad++; $display("FAIL bypass_after_val: got %b expected 0", deq_val); end
        // Without deq_rdy the bypassed message is stored normally
        enq_val = 1'b1; enq_msg = 32'h78; sb.push_back(32'h78);
        tick();
        enq_val = 1'b0;
        #1;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL bypass_store_count: got %0d expected 1", count); end
        exp_msg = sb.pop_front();
        total++; if (deq_msg !== exp_msg) begin bad++; $display("FAIL bypass_store_msg: got %h expected %h", deq_msg, exp_msg); end
        deq_rdy = 1'b1;
        tick();
        deq_rdy = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill_full();
        test_full_simul();
        test_back_to_back();
        test_reset_mid();
`ifdef CMN_VAL_RDY_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmn_val_rdy_queue.md
Name: cmn_val_rdy_queue

Overview:
- Parameterised val/rdy FIFO built from the common register primitives.
- The producer drives the enqueue (writer) end; the consumer drains the dequeue (reader) end.
- Used to decouple pipeline stages and to cross backpressure boundaries between blocks in the same clock domain.
- Supplies the reader end that plain enable registers lack: storage, occupancy tracking and a ready/valid handshake on both sides.

Parameters:
- p_nbits, 32, width of each message in bits (>= 1).
- p_depth, 4, number of entries; must be a power of two and >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all control state immediately.
- enq_val  input  1  producer has a valid message on enq_msg.
- enq_rdy  output  1  queue can accept a message this cycle.
- enq_msg  input  p_nbits  message to enqueue.
- deq_val  output  1  queue has a message on deq_msg.
- deq_rdy  input  1  consumer accepts deq_msg this cycle.
- deq_msg  output  p_nbits  message at the head of the queue.
- count  output  $clog2(p_depth+1)  number of stored entries.

Behaviour:
- Interface: clock is clk; reset is asynchronous, active-high and named reset.
- Reset values:
  - count = 0, deq_val = 0, enq_rdy = 1.
  - Head and tail pointers = 0.
  - Storage array is not reset.
- Fire conditions:
  - Enqueue fires when enq_val && enq_rdy.
  - Dequeue fires when deq_val && deq_rdy.
- Derived outputs:
  - enq_rdy = (count != p_depth).
  - deq_val = (count != 0).
  - Neither depends combinationally on enq_val or deq_rdy in the base configuration.
- Enqueue fire: enq_msg is written to storage[tail] at the clock edge; tail increments.
- Dequeue fire: head increments at the clock edge.
- deq_msg = storage[head] combinationally. It is undefined while deq_val = 0; benches check it only when deq_val = 1.
- Latency: a message enqueued at edge N is visible on deq_msg with deq_val = 1 from cycle N+1 (one-cycle latency).
- Pointers are $clog2(p_depth) bits wide and wrap naturally from p_depth-1 to 0; no modulo logic.
- Count update:
  - +1 on enqueue only, -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue, or when neither fires.
- Boundary conditions:
  - Full (count = p_depth): enq_rdy = 0. A simultaneous deq_rdy does not make room in the same cycle; no enqueue occurs.
  - Empty (count = 0): deq_val = 0. deq_rdy is ignored; head does not move.
  - Partially full with both firing: read and write are to distinct entries; count holds.
  - enq_val asserted while enq_rdy = 0: no state change. The producer must hold enq_msg stable until the enqueue fires.
- Reset mid-operation: asserting reset discards all stored entries immediately (asynchronously). After reset deasserts, the queue is empty and outputs are at reset values.
- Message ordering is strictly FIFO; no entry is dropped or duplicated.

Optional Feature:
- Macro: CMN_VAL_RDY_QUEUE_BYPASS_EN.
- Defined:
  - When count = 0 and enq_val = 1, deq_val = 1 and deq_msg = enq_msg combinationally (zero latency).
  - If deq_rdy = 1 in that cycle, the message passes straight through; storage, pointers and count are unchanged.
  - If deq_rdy = 0, the message is enqueued normally.
- Not defined: base behaviour as above, with the fixed one-cycle minimum latency.

Test Plan:
- Reset, then one enqueue: reset asserted for 2 cycles; check count = 0, deq_val = 0, enq_rdy = 1. Enqueue 0xDEADBEEF → next cycle deq_val = 1, deq_msg = 0xDEADBEEF, count = 1.
- Fill to full: p_depth = 4, enqueue 0x1..0x4 with deq_rdy = 0 → enq_rdy = 0 and count = 4. A fifth enq_val = 1 with msg 0x5 is rejected. Then drain: 0x1, 0x2, 0x3, 0x4 in order.
- Full with simultaneous deq_rdy and enq_val (msg 0x9): one entry leaves and none enters → count = 3. Next cycle enq_rdy = 1.
- Steady state: count = 2, enqueue and dequeue every cycle for 10 cycles with msgs 0x10..0x19 → count stays 2. Output order is the 2 preloaded entries, then 0x10..0x17. Pointers wrap at least twice.
- Reset mid-operation: with count = 3, pulse reset asynchronously between edges → deq_val = 0 and count = 0 immediately. The next enqueue of 0xA5 is the first message dequeued.
- Bypass (macro defined): queue empty, enq_val = 1 with msg 0x77 and deq_rdy = 1 → same cycle deq_val = 1, deq_msg = 0x77. Next cycle count = 0.
